// File: rtl/gray_to_binary_sync.sv
// gray_to_binary_sync: registered Gray->binary decoder for Gray-coded pointers.
//   Stage 1 captures a valid Gray sample; stage 2 decodes it, compares it with
//   the previous valid sample, and flags multi-bit steps (step_err) or repeats
//   (hold). Latency is 2 clocks from g_valid to b_valid, one sample per clock.
// Build option: define GRAY_ERRCNT_EN to build the saturating step-error
//   counter on err_cnt; when it is undefined err_cnt is tied to zero.
module gray_to_binary_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] g_in,
   input  logic             g_valid,
   output logic [WIDTH-1:0] b_out,
   output logic             b_valid,
   output logic             step_err,
   output logic             hold,
   output logic [7:0]       err_cnt
);

   // Stage-1 capture of the incoming Gray sample.
   logic [WIDTH-1:0] g_s1;
   // vld_pipe[0] is the stage-1 valid, vld_pipe[1] drives b_valid.
   logic [1:0]       vld_pipe;

   // History for the step check: last Gray sample seen in stage 2.
   logic [WIDTH-1:0] g_prev;
   logic             have_prev;

   // Stage-2 combinational values computed from g_s1.
   logic [WIDTH-1:0] bin_s1;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] diff_m1;
   logic             multi_bit;
   logic             zero_bit;
   logic             bad_step;
   logic             same_step;

   // Stage 1: register the sample; valid bit follows g_valid, reset drops it.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe[0] <= 1'b0;
         g_s1        <= '0;
      end else begin
         vld_pipe[0] <= g_valid;
         if (g_valid)
            g_s1 <= g_in;
      end
   end

   // Decode and step classification for the sample sitting in stage 1.
   // Each binary bit is the XOR of all Gray bits at or above it. "More than
   // one bit changed" is detected without a popcount: d & (d-1) is nonzero
   // exactly when d has two or more bits set.
   always_comb begin
      bin_s1 = '0;
      for (int i = 0; i < WIDTH; i++)
         bin_s1[i] = ^(g_s1 >> i);
      diff      = g_s1 ^ g_prev;
      diff_m1   = diff - {{(WIDTH-1){1'b0}}, 1'b1};
      multi_bit = |(diff & diff_m1);
      zero_bit  = ~|diff;
      // The first sample after reset has nothing to compare against.
      bad_step  = have_prev & multi_bit;
      same_step = have_prev & zero_bit;
   end

   // Stage 2: publish decoded value and flags, update comparison history.
   // b_out keeps its last value between pulses; flags are pulse-qualified.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe[1] <= 1'b0;
         b_out       <= '0;
         step_err    <= 1'b0;
         hold        <= 1'b0;
         g_prev      <= '0;
         have_prev   <= 1'b0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         if (vld_pipe[0]) begin
            b_out     <= bin_s1;
            step_err  <= bad_step;
            hold      <= same_step;
            g_prev    <= g_s1;
            have_prev <= 1'b1;
         end else begin
            step_err  <= 1'b0;
            hold      <= 1'b0;
         end
      end
   end

   assign b_valid = vld_pipe[1];

`ifdef GRAY_ERRCNT_EN
   logic [7:0] err_cnt_q;

   // Saturating count of step errors; it advances on the same edge that
   // raises step_err, so err_cnt already includes the error being flagged.
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt_q <= 8'd0;
      else if (vld_pipe[0] && bad_step && (err_cnt_q != 8'hFF))
         err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_gray_to_binary_sync.sv
// Directed bench for gray_to_binary_sync (WIDTH=4). Inputs change 1 ns after
// each rising edge; outputs are checked 1 ns after the following edge.
module tb_gray_to_binary_sync;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] g_in = 4'h0;
   logic       g_valid = 1'b0;
   logic [3:0] b_out;
   logic       b_valid;
   logic       step_err;
   logic       hold;
   logic [7:0] err_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Gray code for binary 0..15, written out by hand.
   logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

`ifdef GRAY_ERRCNT_EN
   localparam logic [7:0] EXP_CNT_ONE = 8'd1;
   localparam logic [7:0] EXP_CNT_SAT = 8'd255;
`else
   localparam logic [7:0] EXP_CNT_ONE = 8'd0;
   localparam logic [7:0] EXP_CNT_SAT = 8'd0;
`endif

   gray_to_binary_sync #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .g_in     (g_in),
      .g_valid  (g_valid),
      .b_out    (b_out),
      .b_valid  (b_valid),
      .step_err (step_err),
      .hold     (hold),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   // Drive one cycle of input, then move to 1 ns after the next rising edge.
   task automatic cyc(input logic [3:0] g, input logic v);
      g_in    = g;
      g_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #1;
      // Reset
      rst = 1'b1;
      cyc(4'h0, 1'b0);
      cyc(4'h5, 1'b1);              // reset overrides g_valid
      chk("rst_b_out",    b_out,    0);
      chk("rst_b_valid",  b_valid,  0);
      chk("rst_step_err", step_err, 0);
      chk("rst_hold",     hold,     0);
      chk("rst_err_cnt",  err_cnt,  0);
      rst = 1'b0;
      cyc(4'h0, 1'b0);
      chk("rst_flush_valid", b_valid, 0);

      // Sweep 0..15 followed directly by the wrap to Gray 0000
      for (int k = 0; k < 16; k++) begin
         cyc(gray_tbl[k], 1'b1);
         if (k == 0) begin
            chk("sweep_latency", b_valid, 0);
         end else begin
            chk("sweep_valid", b_valid,  1);
            chk("sweep_b_out", b_out,    k - 1);
            chk("sweep_err",   step_err, 0);
            chk("sweep_hold",  hold,     0);
         end
      end
      cyc(4'h0, 1'b1);
      chk("sweep_last_b_out", b_out,    15);
      chk("sweep_last_err",   step_err, 0);
      cyc(4'h0, 1'b0);
      chk("wrap_valid", b_valid,  1);
      chk("wrap_b_out", b_out,    0);
      chk("wrap_err",   step_err, 0);
      chk("wrap_hold",  hold,     0);
      cyc(4'h0, 1'b0);
      chk("wrap_idle_valid", b_valid, 0);

      // Bad step: 0001 -> 0010
      cyc(4'h1, 1'b1);
      cyc(4'h2, 1'b1);
      chk("bad_first_b_out", b_out,    1);
      chk("bad_first_err",   step_err, 0);
      cyc(4'h0, 1'b0);
      chk("bad_second_b_out", b_out,    3);
      chk("bad_second_err",   step_err, 1);
      chk("bad_second_hold",  hold,     0);
      chk("bad_err_cnt",      err_cnt,  EXP_CNT_ONE);
      cyc(4'h0, 1'b0);
      chk("bad_idle_valid", b_valid,  0);
      chk("bad_idle_err",   step_err, 0);
      chk("bad_idle_cnt",   err_cnt,  EXP_CNT_ONE);

      // Repeat across a gap: 0011, idle x3, 0011
      cyc(4'h3, 1'b1);
      cyc(4'h0, 1'b0);
      chk("rep_first_b_out", b_out, 2);
      chk("rep_first_hold",  hold,  0);
      cyc(4'h0, 1'b0);
      chk("rep_gap_valid", b_valid, 0);
      chk("rep_gap_b_out", b_out,   2);
      cyc(4'h0, 1'b0);
      cyc(4'h3, 1'b1);
      chk("rep_gap2_valid", b_valid, 0);
      chk("rep_gap2_b_out", b_out,   2);
      cyc(4'h0, 1'b0);
      chk("rep_second_valid", b_valid,  1);
      chk("rep_second_b_out", b_out,    2);
      chk("rep_second_hold",  hold,     1);
      chk("rep_second_err",   step_err, 0);
      cyc(4'h0, 1'b0);
      chk("rep_after_hold", hold, 0);

      // Reset mid-stream: 0110 in flight is discarded; 1111 is a first sample
      cyc(4'h6, 1'b1);
      rst = 1'b1;
      cyc(4'h0, 1'b0);
      chk("midrst_valid", b_valid, 0);
      chk("midrst_b_out", b_out,   0);
      chk("midrst_cnt",   err_cnt, 0);
      rst = 1'b0;
      cyc(4'hF, 1'b1);
      chk("midrst_no_pulse", b_valid, 0);
      cyc(4'h0, 1'b0);
      chk("midrst_new_valid", b_valid,  1);
      chk("midrst_new_b_out", b_out,    10);
      chk("midrst_new_err",   step_err, 0);
      chk("midrst_new_hold",  hold,     0);

      // Saturation: 300 alternating 0000/0011 samples after a reset
      rst = 1'b1;
      cyc(4'h0, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 300; k++) begin
         cyc((k % 2 == 0) ? 4'h0 : 4'h3, 1'b1);
         if (k == 2) chk("sat_step_err", step_err, 1);
      end
      cyc(4'h0, 1'b0);
      cyc(4'h0, 1'b0);
      chk("sat_cnt", err_cnt, EXP_CNT_SAT);
      cyc(4'h3, 1'b1);
      cyc(4'h0, 1'b1);
      cyc(4'h0, 1'b0);
      cyc(4'h0, 1'b0);
      chk("sat_cnt_stays", err_cnt, EXP_CNT_SAT);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
